// File: rtl/data_sram_responder.sv
// Single-cycle synchronous data RAM with byte-lane writes, a post-reset clear pass
// and write-side error/activity counters.
module data_sram_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic        wr_err,
    output logic [15:0] wr_err_cnt,
    output logic [15:0] wr_cnt
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {StInit, StReady} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   wr_err_q, wr_err_d;
    logic [15:0]            wr_err_cnt_q, wr_err_cnt_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;
    logic [31:0]            mem_q [DEPTH];

    logic [3:0]             mem_be;
    logic [ADDR_BITS-1:0]   mem_idx;
    logic [31:0]            mem_wdata;

    logic [ADDR_BITS-1:0]   idx;
    logic                   in_range;
    logic                   is_wr;
    logic                   unused_addr_lsb;

    assign idx             = data_sram_addr[ADDR_BITS+1:2];
    assign in_range        = (data_sram_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign is_wr           = data_sram_en & (|data_sram_we);
    assign unused_addr_lsb = ^data_sram_addr[1:0];

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        rdata_d      = rdata_q;
        wr_err_d     = wr_err_q;
        wr_err_cnt_d = wr_err_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        mem_be       = 4'h0;
        mem_idx      = idx;
        mem_wdata    = data_sram_wdata;

        unique case (state_q)
            StInit: begin
                // Requests are ignored while the array is being zeroed.
                mem_be    = 4'hF;
                mem_idx   = clr_idx_q;
                mem_wdata = 32'h0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (&clr_idx_q) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (data_sram_en) begin
                    if (in_range) begin
                        // Read-first: the old word is returned even when written.
                        rdata_d = mem_q[idx];
                        if (is_wr) begin
                            mem_be   = data_sram_we;
                            wr_cnt_d = wr_cnt_q + 16'd1;
                        end
                    end else begin
                        rdata_d = 32'h0;
                        if (is_wr) begin
                            wr_err_d = 1'b1;
                            if (wr_err_cnt_q != 16'hFFFF) begin
                                wr_err_cnt_d = wr_err_cnt_q + 16'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            clr_idx_q    <= '0;
            rdata_q      <= 32'h0;
            wr_err_q     <= 1'b0;
            wr_err_cnt_q <= 16'h0;
            wr_cnt_q     <= 16'h0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            rdata_q      <= rdata_d;
            wr_err_q     <= wr_err_d;
            wr_err_cnt_q <= wr_err_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    // Array has no reset of its own; the INIT pass zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign init_done       = (state_q == StReady);
    assign wr_err          = wr_err_q;
    assign wr_err_cnt      = wr_err_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule
